csr_exec_unit: RTL and testbench
================================

Name: csr_exec_unit

Overview:
- Execute-side sequencer that sits directly upstream of the CSR register file.
- Accepts one CSR instruction at a time from the execute stage over a valid/ready handshake.
- Performs the read-modify-write against the CSR file: read the old value, compute the new value, issue a single write strobe.
- Returns the old CSR value plus the destination register index to writeback over a second valid/ready handshake.

Parameters:
- XLEN, 32, data width of CSR values and operands.
- ADDR_W, 12, CSR address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  execute stage presents a CSR instruction.
- req_ready  out  1  unit can accept a request.
- req_cmd  in  Bundle::ControlRegisterCommand  CSR_N/W/S/C/I.
- req_addr  in  ADDR_W  CSR address.
- req_src  in  XLEN  rs1 value, or zero-extended 5-bit zimm for CSR_I.
- req_rd  in  5  destination register index.
- csr  out  ADDR_W  address to the CSR file.
- csr_cmd  out  Bundle::ControlRegisterCommand  write command to the CSR file; CSR_N except during the write cycle.
- csr_wdata  out  XLEN  computed new value.
- csr_rdata  in  XLEN  current value from the CSR file.
- resp_valid  out  1  result available.
- resp_ready  in  1  writeback accepts the result.
- resp_data  out  XLEN  old CSR value.
- resp_rd  out  5  destination register index.

Behaviour:
- Reset (async, rst_n low): state=IDLE, req_ready=1, resp_valid=0, csr_cmd=CSR_N, csr=0, csr_wdata=0, resp_data=0, resp_rd=0. Reset mid-operation aborts the operation and issues no write strobe.
- FSM states: IDLE, READ, WRITE, RESP.
- IDLE: req_ready=1. On req_valid, latch cmd/addr/src/rd.
  - cmd==CSR_N goes straight to RESP with resp_data=0.
  - Any other cmd goes to READ.
- READ (1 cycle): csr=latched addr, csr_cmd=CSR_N; capture csr_rdata into old register. Go to WRITE.
- WRITE (1 cycle): csr_cmd=latched cmd, csr_wdata per the rules below. Go to RESP.
  - W: wdata = src.
  - I: wdata = src (immediate form).
  - S: wdata = old | src.
  - C: wdata = old & ~src.
  - Write suppression: S or C with src==0 drives csr_cmd=CSR_N (read-only access, no side effect).
- RESP: resp_valid=1, resp_data=old, resp_rd=latched rd. Hold all outputs stable until resp_ready. Same cycle as resp_ready, return to IDLE.
- Latency: request accepted at cycle 0 → write strobe at cycle 2 → resp_valid at cycle 3.
- Throughput: one instruction per 4 cycles minimum; req_ready=0 outside IDLE.
- Request inputs are ignored outside IDLE. A request arriving while in RESP waits; there is no bypass.
- csr_cmd is high (non-CSR_N) for exactly one cycle per write.

Optional Feature:
- Macro: CSR_EXEC_PERF_EN.
- Defined: adds a 32-bit retired-operation counter.
  - Reset value 0.
  - Increments on each resp_valid && resp_ready, including CSR_N.
  - Wraps from 0xFFFFFFFF to 0.
  - Address 12'hC00 is intercepted: READ captures the counter instead of csr_rdata, and WRITE never strobes for this address (read-only).
- Undefined: no counter; 12'hC00 is forwarded to the CSR file like any other address.

Decomposition:
- Bundle package additions:
  - CsrExecState enum {IDLE, READ, WRITE, RESP}.
  - CSR_ADDR_PERF = 12'hC00.
  - Reuse the existing ControlRegisterCommand.
- One natural combinational sub-module, csr_wdata_alu: inputs cmd, old, src; outputs wdata and write_en (applies the suppression rule). Instantiated once in the WRITE path.

Test Plan:
- W to 12'hF: old=0x00000005, src=0x12345678 → one-cycle csr_cmd=CSR_W at cycle 2 with wdata 0x12345678; resp_data=0x00000005 at cycle 3.
- S then C: old=0x000000F0, S src=0x0000000F → wdata 0x000000FF; next C src=0x000000F0 → wdata 0x0000000F, resp_data 0x000000FF.
- S with src=0 on old=0xDEADBEEF → csr_cmd stays CSR_N for all cycles; resp_data=0xDEADBEEF.
- Backpressure: resp_ready=0 for 5 cycles → resp_valid, resp_data and resp_rd held stable; req_ready=0 throughout; second request accepted the cycle after the handshake.
- Reset asserted during WRITE state → no csr_cmd strobe; all outputs at reset values immediately (asynchronous); first request after reset completes normally.
- With CSR_EXEC_PERF_EN defined: 3 completed ops, then S to 12'hC00 → resp_data=3 and no write strobe. Counter preset to 0xFFFFFFFF plus one op → reads 0.

Source files
------------

// File: rtl/csr_exec_unit_pkg.sv
// Shared types for the CSR execute sequencer: the CSR command encoding,
// the sequencer state encoding and the address of the retired-op counter.
package csr_exec_unit_pkg;

    // CSR command carried from decode to the CSR file.
    typedef enum logic [2:0] {
        CSR_N = 3'd0,   // no access / no write
        CSR_W = 3'd1,   // write src
        CSR_S = 3'd2,   // set bits in src
        CSR_C = 3'd3,   // clear bits in src
        CSR_I = 3'd4    // write zero-extended immediate
    } control_register_command_t;

    // Read-modify-write sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } csr_exec_state_t;

    // Read-only retired-operation counter, served locally when enabled.
    localparam logic [11:0] CSR_ADDR_PERF = 12'hC00;

endpackage

// File: rtl/csr_exec_unit_if.sv
// Request/response channels between the execute stage and the CSR sequencer.
//
// Handshake rule for both channels: a transfer happens on a rising clock
// edge where valid and ready are both high. The producer holds valid and its
// payload stable until that edge; ready may change freely and never depends
// on valid combinationally in a way that could loop.
interface csr_exec_unit_if
    import csr_exec_unit_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 12
);
    logic                      req_valid;
    logic                      req_ready;
    control_register_command_t req_cmd;
    logic [ADDR_W-1:0]         req_addr;
    logic [XLEN-1:0]           req_src;
    logic [4:0]                req_rd;

    logic                      resp_valid;
    logic                      resp_ready;
    logic [XLEN-1:0]           resp_data;
    logic [4:0]                resp_rd;

    // Execute-stage side: issues requests, consumes responses.
    modport master (
        output req_valid, req_cmd, req_addr, req_src, req_rd, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_rd
    );

    // Sequencer side: accepts requests, produces responses.
    modport slave (
        input  req_valid, req_cmd, req_addr, req_src, req_rd, resp_ready,
        output req_ready, resp_valid, resp_data, resp_rd
    );
endinterface

// File: rtl/csr_wdata_alu.sv
// New-value computation for a CSR read-modify-write. Set/clear with an
// all-zero operand is a pure read, so write_en drops for those.
module csr_wdata_alu
    import csr_exec_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  control_register_command_t cmd,
    input  logic [XLEN-1:0]           old,
    input  logic [XLEN-1:0]           src,
    output logic [XLEN-1:0]           wdata,
    output logic                      write_en
);

    // Combine old value and operand according to the command.
    always_comb begin
        wdata    = '0;
        write_en = 1'b0;
        case (cmd)
            CSR_W, CSR_I: begin
                wdata    = src;
                write_en = 1'b1;
            end
            CSR_S: begin
                wdata    = old | src;
                write_en = |src;
            end
            CSR_C: begin
                wdata    = old & ~src;
                write_en = |src;
            end
            default: begin
                wdata    = '0;
                write_en = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/csr_exec_unit.sv
// CSR execute sequencer: accepts one CSR instruction, reads the old value,
// issues at most one write strobe with the new value, then returns the old
// value and rd to writeback.
// Optional feature macro: CSR_EXEC_PERF_EN adds a read-only 32-bit
// retired-operation counter served at CSR_ADDR_PERF (12'hC00).
module csr_exec_unit
    import csr_exec_unit_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 12
) (
    input  logic                      clk,
    input  logic                      rst_n,
    csr_exec_unit_if.slave            bus,
    output logic [ADDR_W-1:0]         csr,
    output control_register_command_t csr_cmd,
    output logic [XLEN-1:0]           csr_wdata,
    input  logic [XLEN-1:0]           csr_rdata,
    output csr_exec_state_t           state_dbg
);

    csr_exec_state_t           state;
    csr_exec_state_t           state_next;
    control_register_command_t cmd_q;
    logic [ADDR_W-1:0]         addr_q;
    logic [XLEN-1:0]           src_q;
    logic [4:0]                rd_q;
    logic [XLEN-1:0]           old_q;

    logic                      accept;
    logic                      req_ready;
    logic                      resp_valid;
    logic [XLEN-1:0]           alu_wdata;
    logic                      alu_write_en;
    logic                      write_en;
    logic [XLEN-1:0]           read_value;

    csr_wdata_alu #(.XLEN(XLEN)) u_wdata_alu (
        .cmd      (cmd_q),
        .old      (old_q),
        .src      (src_q),
        .wdata    (alu_wdata),
        .write_en (alu_write_en)
    );

`ifdef CSR_EXEC_PERF_EN
    logic [31:0] perf_cnt;
    logic        is_perf;

    assign is_perf    = (addr_q == CSR_ADDR_PERF);
    assign read_value = is_perf ? XLEN'(perf_cnt) : csr_rdata;
    assign write_en   = alu_write_en & ~is_perf;

    // Count every retired instruction, CSR_N included; wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cnt <= '0;
        end else if (resp_valid && bus.resp_ready) begin
            perf_cnt <= perf_cnt + 32'd1;
        end
    end
`else
    assign read_value = csr_rdata;
    assign write_en   = alu_write_en;
`endif

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, handshake outputs and the single-cycle write strobe.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        accept     = 1'b0;
        csr_cmd    = CSR_N;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (bus.req_valid) begin
                    accept     = 1'b1;
                    state_next = (bus.req_cmd == CSR_N) ? RESP : READ;
                end
            end
            READ: begin
                state_next = WRITE;
            end
            WRITE: begin
                if (write_en) begin
                    csr_cmd = cmd_q;
                end
                state_next = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (bus.resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Latch the request on acceptance and capture the old value in READ.
    // old_q is cleared on acceptance so CSR_N responds with zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q  <= CSR_N;
            addr_q <= '0;
            src_q  <= '0;
            rd_q   <= '0;
            old_q  <= '0;
        end else if (accept) begin
            cmd_q  <= bus.req_cmd;
            addr_q <= bus.req_addr;
            src_q  <= bus.req_src;
            rd_q   <= bus.req_rd;
            old_q  <= '0;
        end else if (state == READ) begin
            old_q  <= read_value;
        end
    end

    assign bus.req_ready  = req_ready;
    assign bus.resp_valid = resp_valid;
    assign bus.resp_data  = old_q;
    assign bus.resp_rd    = rd_q;
    assign csr            = addr_q;
    assign csr_wdata      = alu_wdata;
    assign state_dbg      = state;

endmodule

// File: tb/tb_csr_exec_unit.sv
// Bench for csr_exec_unit: table of CSR instructions with expected write and
// response, random RMW traffic, backpressure, async reset mid-write and,
// when CSR_EXEC_PERF_EN is defined, the retired-op counter.
module tb_csr_exec_unit;
    import csr_exec_unit_pkg::*;

    typedef struct {
        control_register_command_t cmd;
        logic [11:0]               addr;
        logic [31:0]               src;
        logic [31:0]               old;
        logic [4:0]                rd;
        logic                      exp_wr;
        logic [31:0]               exp_wdata;
        logic [31:0]               exp_resp;
    } txn_t;

    logic                      clk;
    logic                      rst_n;
    logic [11:0]               csr;
    control_register_command_t csr_cmd;
    logic [31:0]               csr_wdata;
    logic [31:0]               csr_rdata;
    csr_exec_state_t           state_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    logic [46:0] wr_exp_q[$];    // {cmd, addr, wdata}
    logic [36:0] resp_exp_q[$];  // {rd, data}

    csr_exec_unit_if #(.XLEN(32), .ADDR_W(12)) bus ();

    csr_exec_unit #(.XLEN(32), .ADDR_W(12)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .csr       (csr),
        .csr_cmd   (csr_cmd),
        .csr_wdata (csr_wdata),
        .csr_rdata (csr_rdata),
        .state_dbg (state_dbg)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic txn_t make_txn(control_register_command_t cmd, logic [11:0] addr,
                                      logic [31:0] src, logic [31:0] old, logic [4:0] rd);
        txn_t t;
        t.cmd  = cmd;
        t.addr = addr;
        t.src  = src;
        t.old  = old;
        t.rd   = rd;
        case (cmd)
            CSR_W, CSR_I: begin t.exp_wr = 1'b1;      t.exp_wdata = src;        end
            CSR_S:        begin t.exp_wr = (src != 0); t.exp_wdata = old | src;  end
            CSR_C:        begin t.exp_wr = (src != 0); t.exp_wdata = old & ~src; end
            default:      begin t.exp_wr = 1'b0;      t.exp_wdata = 32'h0;      end
        endcase
        t.exp_resp = (cmd == CSR_N) ? 32'h0 : old;
        return t;
    endfunction

    // Scoreboard: compare write strobes and response handshakes as they occur.
    always @(negedge clk) begin
        if (rst_n && csr_cmd != CSR_N) begin
            if (wr_exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got cmd %0d addr %0h wdata %0h required none",
                         csr_cmd, csr, csr_wdata);
            end else begin
                check("csr_write", 64'({csr_cmd, csr, csr_wdata}), 64'(wr_exp_q.pop_front()));
            end
        end
        if (rst_n && bus.resp_valid && bus.resp_ready) begin
            if (resp_exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_resp: got rd %0d data %0h required none",
                         bus.resp_rd, bus.resp_data);
            end else begin
                check("resp", 64'({bus.resp_rd, bus.resp_data}), 64'(resp_exp_q.pop_front()));
            end
        end
    end

    // Driver: one full instruction, with hold cycles of response backpressure.
    task automatic do_txn(input txn_t e, input int hold);
        int strobe_at = -1;
        int n_strobe  = 0;
        int resp_at   = -1;
        logic [31:0] cap_data;
        logic [4:0]  cap_rd;
        @(posedge clk);
        #1;
        check("req_ready_idle", 64'(bus.req_ready), 64'(1));
        bus.resp_ready = (hold == 0);
        csr_rdata      = e.old;
        bus.req_valid  = 1'b1;
        bus.req_cmd    = e.cmd;
        bus.req_addr   = e.addr;
        bus.req_src    = e.src;
        bus.req_rd     = e.rd;
        for (int n = 0; n < 20 && !bus.req_ready; n++) begin
            @(posedge clk);
            #1;
        end
        if (!bus.req_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL req_accept_timeout: got req_ready 0 required 1");
            bus.req_valid = 1'b0;
            return;
        end
        if (e.exp_wr) wr_exp_q.push_back({e.cmd, e.addr, e.exp_wdata});
        resp_exp_q.push_back({e.rd, e.exp_resp});
        @(posedge clk);
        #1;
        // Busy-period junk on the request channel must be ignored.
        bus.req_cmd  = CSR_W;
        bus.req_addr = ~e.addr;
        bus.req_src  = ~e.src;
        bus.req_rd   = ~e.rd;
        for (int k = 1; k <= 12; k++) begin
            if (k == 1 && e.cmd != CSR_N) check("csr_addr_read", 64'(csr), 64'(e.addr));
            if (csr_cmd != CSR_N) begin
                n_strobe++;
                if (strobe_at < 0) strobe_at = k;
            end
            if (bus.resp_valid) begin
                resp_at = k;
                break;
            end
            @(posedge clk);
            #1;
        end
        bus.req_valid = 1'b0;
        check("resp_latency", 64'(resp_at), 64'((e.cmd == CSR_N) ? 1 : 3));
        check("strobe_cycle", 64'(strobe_at), 64'(e.exp_wr ? 2 : -1));
        check("strobe_count", 64'(n_strobe), 64'(e.exp_wr ? 1 : 0));
        if (resp_at < 0) begin
            bus.resp_ready = 1'b1;
            return;
        end
        cap_data = bus.resp_data;
        cap_rd   = bus.resp_rd;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            check("bp_resp_valid", 64'(bus.resp_valid), 64'(1));
            check("bp_resp_data", 64'(bus.resp_data), 64'(cap_data));
            check("bp_resp_rd", 64'(bus.resp_rd), 64'(cap_rd));
            check("bp_req_ready", 64'(bus.req_ready), 64'(0));
        end
        bus.resp_ready = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 64'(bus.req_ready), 64'(1));
        check({tag, "_resp_valid"}, 64'(bus.resp_valid), 64'(0));
        check({tag, "_csr_cmd"}, 64'(csr_cmd), 64'(CSR_N));
        check({tag, "_csr"}, 64'(csr), 64'(0));
        check({tag, "_csr_wdata"}, 64'(csr_wdata), 64'(0));
        check({tag, "_resp_data"}, 64'(bus.resp_data), 64'(0));
        check({tag, "_resp_rd"}, 64'(bus.resp_rd), 64'(0));
        check({tag, "_state"}, 64'(state_dbg), 64'(IDLE));
    endtask

    initial begin
        txn_t tbl[$];
        txn_t t;
        control_register_command_t rc;
        logic [31:0] rsrc;

        rst_n          = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_cmd    = CSR_N;
        bus.req_addr   = '0;
        bus.req_src    = '0;
        bus.req_rd     = '0;
        bus.resp_ready = 1'b1;
        csr_rdata      = '0;
        #2;
        check_reset_outputs("por");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors
        tbl.push_back('{CSR_W, 12'h00F, 32'h12345678, 32'h00000005, 5'd1,  1'b1, 32'h12345678, 32'h00000005});
        tbl.push_back('{CSR_S, 12'h300, 32'h0000000F, 32'h000000F0, 5'd2,  1'b1, 32'h000000FF, 32'h000000F0});
        tbl.push_back('{CSR_C, 12'h300, 32'h000000F0, 32'h000000FF, 5'd3,  1'b1, 32'h0000000F, 32'h000000FF});
        tbl.push_back('{CSR_S, 12'h340, 32'h00000000, 32'hDEADBEEF, 5'd4,  1'b0, 32'h0,        32'hDEADBEEF});
        tbl.push_back('{CSR_C, 12'h341, 32'h00000000, 32'hCAFEF00D, 5'd5,  1'b0, 32'h0,        32'hCAFEF00D});
        tbl.push_back('{CSR_I, 12'h305, 32'h0000001F, 32'hAAAA0000, 5'd6,  1'b1, 32'h0000001F, 32'hAAAA0000});
        tbl.push_back('{CSR_N, 12'h123, 32'h0000FFFF, 32'h00000077, 5'd7,  1'b0, 32'h0,        32'h00000000});
        tbl.push_back('{CSR_C, 12'h344, 32'hFFFFFFFF, 32'h12345678, 5'd31, 1'b1, 32'h00000000, 32'h12345678});
        tbl.push_back('{CSR_W, 12'hFFF, 32'h00000000, 32'hFFFFFFFF, 5'd0,  1'b1, 32'h00000000, 32'hFFFFFFFF});
`ifndef CSR_EXEC_PERF_EN
        tbl.push_back('{CSR_S, 12'hC00, 32'h0000000A, 32'h00000055, 5'd9,  1'b1, 32'h0000005F, 32'h00000055});
`endif
        foreach (tbl[i]) do_txn(tbl[i], 0);

        // Random read-modify-write traffic
        for (int i = 0; i < 8; i++) begin
            rc   = control_register_command_t'($urandom_range(1, 4));
            rsrc = (rc == CSR_I) ? 32'($urandom_range(0, 31)) : $urandom;
            if (rc != CSR_I && $urandom_range(0, 3) == 0) rsrc = 32'h0;
            t = make_txn(rc, 12'($urandom_range(12'h300, 12'h3FF)), rsrc, $urandom,
                         5'($urandom_range(0, 31)));
            do_txn(t, 0);
        end

        // Backpressure, then an immediate follow-up request
        do_txn(make_txn(CSR_W, 12'h010, 32'h0BADF00D, 32'h11112222, 5'd12), 5);
        do_txn(make_txn(CSR_S, 12'h011, 32'h00000100, 32'h00000001, 5'd13), 0);

        // Async reset asserted in WRITE: no write reaches a clock edge
        @(posedge clk);
        #1;
        csr_rdata     = 32'h00000022;
        bus.req_valid = 1'b1;
        bus.req_cmd   = CSR_W;
        bus.req_addr  = 12'h0AB;
        bus.req_src   = 32'h00001111;
        bus.req_rd    = 5'd14;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        check("rst_seq_state_read", 64'(state_dbg), 64'(READ));
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_write_reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        do_txn(make_txn(CSR_W, 12'h0AB, 32'h00001111, 32'h00000022, 5'd14), 0);

`ifdef CSR_EXEC_PERF_EN
        // Retired-op counter: count three ops, then read it back
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        do_txn(make_txn(CSR_N, 12'h001, 32'h0, 32'h0, 5'd1), 0);
        do_txn(make_txn(CSR_W, 12'h002, 32'h5, 32'h6, 5'd2), 0);
        do_txn(make_txn(CSR_S, 12'h003, 32'h0, 32'h7, 5'd3), 0);
        t = make_txn(CSR_S, 12'hC00, 32'h1, 32'hABCD, 5'd10);
        t.exp_wr   = 1'b0;
        t.exp_resp = 32'd3;
        do_txn(t, 0);
        // Counter wrap
        @(posedge clk);
        #1;
        force dut.perf_cnt = 32'hFFFFFFFF;
        @(posedge clk);
        #1;
        release dut.perf_cnt;
        do_txn(make_txn(CSR_N, 12'h004, 32'h0, 32'h0, 5'd4), 0);
        t = make_txn(CSR_C, 12'hC00, 32'hFFFFFFFF, 32'h1234, 5'd11);
        t.exp_wr   = 1'b0;
        t.exp_resp = 32'd0;
        do_txn(t, 0);
`endif

        repeat (3) @(posedge clk);
        #1;
        check("wr_queue_drained", 64'(wr_exp_q.size()), 64'(0));
        check("resp_queue_drained", 64'(resp_exp_q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL global_timeout: got no end of test required finish");
        $fatal(1, "timeout");
    end

endmodule
